nios2_qsys_cpu_ocimem_ctrl: RTL and testbench

- Downstream consumer of the debug-slave sysclk stage: takes `jdo` and the `take_*_ocimem_*` strobes and performs JTAG accesses to the CPU's on-chip debug memory (OCI RAM).
- Also serves the CPU's debug-memory Avalon slave port and arbitrates between the two.
- Returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave tck stage, which scans them out.

---
 rtl/nios2_qsys_cpu_ocimem_ctrl_pkg.sv | 15 +
 rtl/nios2_qsys_cpu_ocimem_ram.sv | 20 ++
 rtl/nios2_qsys_cpu_ocimem_ctrl.sv | 115 +++++++++++
 tb/tb_nios2_qsys_cpu_ocimem_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_qsys_cpu_ocimem_ctrl_pkg.sv
// nios2_qsys_cpu_ocimem_ctrl_pkg: shared FSM state type and jdo field positions
package nios2_qsys_cpu_ocimem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        JTAG_RD,
        CPU_RD
    } state_t;

    localparam int JDO_RD_REQ    = 34;
    localparam int JDO_CLR_ERR   = 35;
    localparam int JDO_ADDR_LSB  = 26;
    localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios2_qsys_cpu_ocimem_ram.sv
// nios2_qsys_cpu_ocimem_ram: single-port byte-enabled 32-bit RAM with registered read
module nios2_qsys_cpu_ocimem_ram #(
  parameter int ADDR_W    = 8,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_q
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (i_we)
      for (int b = 0; b < 4; b++)
        if (i_be[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    o_q <= mem[i_addr];
  end
endmodule

// File: rtl/nios2_qsys_cpu_ocimem_ctrl.sv
// nios2_qsys_cpu_ocimem_ctrl: arbitrates JTAG debug commands and the CPU Avalon port onto the OCI RAM
// Ports: clk/reset_n; jdo + take_* strobes (JTAG commands from the debug-slave sysclk stage);
//        cpu_* Avalon debug-memory slave; MonDReg/monitor_ready/monitor_error back to the tck stage.
module nios2_qsys_cpu_ocimem_ctrl
    import nios2_qsys_cpu_ocimem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    input  logic              cpu_debugaccess,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_mon_a, w_ram_addr;
    logic [31:0]       r_mon_d, r_cpu_rdata, r_pend_wdata, w_ram_wdata, w_ram_q;
    logic [3:0]        w_ram_be;
    logic              r_pend, r_pend_wr, r_pend_inc, r_err;
    logic              w_take_a, w_take_n, w_take_b, w_queue, w_accept, w_overrun;
    logic              w_idle, w_jtag_go, w_cpu_go, w_cpu_wr, w_ram_we, w_inc, w_unused;

    assign w_take_a  = take_action_ocimem_a;
    assign w_take_n  = ~take_action_ocimem_a & take_no_action_ocimem_a;
    assign w_take_b  = ~take_action_ocimem_a & ~take_no_action_ocimem_a & take_action_ocimem_b;
    assign w_queue   = (w_take_a & jdo[JDO_RD_REQ]) | w_take_n | w_take_b;
    assign w_accept  = w_queue & ~r_pend;
    assign w_overrun = w_queue & r_pend;
    assign w_unused  = ^{jdo[37:36], jdo[2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // a JTAG command accepted this cycle already counts as pending, so the CPU never overtakes it
    always_comb begin
        w_state_nxt = (r_state != IDLE)        ? IDLE    :
                      (r_pend && !r_pend_wr)   ? JTAG_RD :
                      (w_cpu_go && cpu_read)   ? CPU_RD  : IDLE;
    end

    always_comb begin
        w_idle          = r_state == IDLE;
        w_jtag_go       = w_idle & r_pend;
        w_cpu_go        = w_idle & ~r_pend & ~w_accept;
        w_cpu_wr        = w_cpu_go & ~cpu_read & cpu_write;
        cpu_waitrequest = ~(w_cpu_wr | (r_state == CPU_RD));
        w_ram_addr      = w_jtag_go ? r_mon_a : cpu_address;
        w_ram_we        = w_jtag_go ? r_pend_wr : (w_cpu_wr & cpu_debugaccess);
        w_ram_be        = w_jtag_go ? 4'hF : cpu_byteenable;
        w_ram_wdata     = w_jtag_go ? r_pend_wdata : cpu_writedata;
        w_inc           = (w_jtag_go & r_pend_wr) | ((r_state == JTAG_RD) & r_pend_inc);
    end

    // an explicit address load beats the post-increment of an access completing in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mon_a      <= '0;
            r_mon_d      <= '0;
            r_cpu_rdata  <= '0;
            r_err        <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_wr    <= 1'b0;
            r_pend_inc   <= 1'b0;
            r_pend_wdata <= '0;
        end else begin
            if (w_take_a && !w_overrun) r_mon_a <= jdo[JDO_ADDR_LSB +: ADDR_W];
            else if (w_inc)             r_mon_a <= r_mon_a + ADDR_W'(1);
            if (r_state == JTAG_RD) r_mon_d <= w_ram_q;
            if (r_state == CPU_RD)  r_cpu_rdata <= w_ram_q;
            r_err <= w_overrun | (r_err & ~(w_take_a & jdo[JDO_CLR_ERR]));
            if (w_accept) begin
                r_pend       <= 1'b1;
                r_pend_wr    <= w_take_b;
                r_pend_inc   <= ~w_take_a;
                r_pend_wdata <= jdo[JDO_WDATA_LSB +: 32];
            end else if ((w_jtag_go & r_pend_wr) | (r_state == JTAG_RD)) begin
                r_pend <= 1'b0;
            end
        end
    end

    nios2_qsys_cpu_ocimem_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

    assign cpu_readdata  = r_cpu_rdata;
    assign MonDReg       = r_mon_d;
    assign monitor_ready = ~r_pend;
    assign monitor_error = r_err;

endmodule

// File: tb/tb_nios2_qsys_cpu_ocimem_ctrl.sv
// tb_nios2_qsys_cpu_ocimem_ctrl: vector table, corner sequences and random ops against a memory model
module tb_nios2_qsys_cpu_ocimem_ctrl;

    localparam int K_SETA = 0, K_JWR = 1, K_JRDA = 2, K_JRDN = 3, K_CWR = 4, K_CRD = 5;

    typedef struct {
        int          k;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        dbg;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [7:0]  cpu_address;
    logic        cpu_read, cpu_write, cpu_debugaccess;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata, MonDReg;
    logic        cpu_waitrequest, monitor_ready, monitor_error;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] m_mem [256];
    logic [7:0]  m_a;
    vec_t        tbl [20];

    nios2_qsys_cpu_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_debugaccess         (cpu_debugaccess),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] ja(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] j;
        j = '0;
        j[33:26] = a;
        j[34] = rd;
        j[35] = clr;
        return j;
    endfunction

    function automatic logic [37:0] jb(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic a, input logic n, input logic b, input logic [37:0] j);
        take_action_ocimem_a = a;
        take_no_action_ocimem_a = n;
        take_action_ocimem_b = b;
        jdo = j;
        step;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        jdo = '0;
    endtask

    task automatic settle(output int n);
        n = 0;
        while (!monitor_ready && n < 10) begin
            step;
            n++;
        end
    endtask

    task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic dbg, output int waits);
        cpu_address = a;
        cpu_read = ~wr;
        cpu_write = wr;
        cpu_writedata = d;
        cpu_byteenable = be;
        cpu_debugaccess = dbg;
        waits = 0;
        #1;
        while (cpu_waitrequest && waits < 20) begin
            step;
            waits++;
            #1;
        end
        step;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic do_op(input int k, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic dbg, output logic [31:0] got, output logic [31:0] exp);
        int w;
        got = '0;
        exp = '0;
        case (k)
            K_SETA: begin
                strobe(1'b1, 1'b0, 1'b0, ja(a, 1'b0, 1'b0));
                chk("seta_ready", 32'(monitor_ready), 32'd1);
                m_a = a;
            end
            K_JWR: begin
                strobe(1'b0, 1'b0, 1'b1, jb(d));
                settle(w);
                chk("jwr_latency", 32'(w), 32'd1);
                m_mem[m_a] = d;
                m_a++;
            end
            K_JRDA: begin
                strobe(1'b1, 1'b0, 1'b0, ja(a, 1'b1, 1'b0));
                settle(w);
                chk("jrda_latency", 32'(w), 32'd2);
                m_a = a;
                got = MonDReg;
                exp = m_mem[a];
            end
            K_JRDN: begin
                strobe(1'b0, 1'b1, 1'b0, '0);
                settle(w);
                chk("jrdn_latency", 32'(w), 32'd2);
                got = MonDReg;
                exp = m_mem[m_a];
                m_a++;
            end
            K_CWR: begin
                cpu_op(1'b1, a, d, be, dbg, w);
                chk("cwr_waits", 32'(w), 32'd0);
                if (dbg)
                    for (int i = 0; i < 4; i++)
                        if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
            end
            default: begin
                cpu_op(1'b0, a, d, be, dbg, w);
                chk("crd_waits", 32'(w), 32'd1);
                got = cpu_readdata;
                exp = m_mem[a];
            end
        endcase
    endtask

    initial begin
        int w;
        logic [31:0] got, exp;
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        cpu_address = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = '0;
        cpu_byteenable = '0;
        cpu_debugaccess = 1'b0;
        m_a = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step;
        chk("rst_ready", 32'(monitor_ready), 32'd1);
        chk("rst_error", 32'(monitor_error), 32'd0);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_waitreq", 32'(cpu_waitrequest), 32'd1);
        chk("rst_readdata", cpu_readdata, 32'h0);

        for (int i = 0; i < 256; i++) begin
            cpu_op(1'b1, 8'(i), 32'h0, 4'hF, 1'b1, w);
            m_mem[i] = 32'h0;
        end

        do_op(K_SETA, 8'h10, 32'h0, 4'h0, 1'b0, got, exp);
        do_op(K_JWR, 8'h00, 32'hDEADBEEF, 4'h0, 1'b0, got, exp);
        strobe(1'b1, 1'b0, 1'b0, ja(8'h10, 1'b1, 1'b0));
        chk("rb_grant_ready", 32'(monitor_ready), 32'd0);
        chk("rb_grant_mondreg", MonDReg, 32'h0);
        step;
        chk("rb_jtagrd_ready", 32'(monitor_ready), 32'd0);
        chk("rb_jtagrd_mondreg", MonDReg, 32'h0);
        step;
        chk("rb_done_mondreg", MonDReg, 32'hDEADBEEF);
        chk("rb_done_ready", 32'(monitor_ready), 32'd1);
        m_a = 8'h10;

        tbl[0]  = '{K_SETA, 8'h10, 32'h0,        4'h0, 1'b0, 32'h0};
        tbl[1]  = '{K_JWR,  8'h00, 32'hDEADBEEF, 4'h0, 1'b0, 32'h0};
        tbl[2]  = '{K_JRDA, 8'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{K_JRDN, 8'h00, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        tbl[4]  = '{K_JRDN, 8'h00, 32'h0,        4'h0, 1'b0, 32'h0};
        tbl[5]  = '{K_CWR,  8'h00, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h0};
        tbl[6]  = '{K_CWR,  8'h01, 32'h11111111, 4'hF, 1'b1, 32'h0};
        tbl[7]  = '{K_SETA, 8'hFF, 32'h0,        4'h0, 1'b0, 32'h0};
        tbl[8]  = '{K_JWR,  8'h00, 32'h00000001, 4'h0, 1'b0, 32'h0};
        tbl[9]  = '{K_JRDN, 8'h00, 32'h0,        4'h0, 1'b0, 32'hA5A5A5A5};
        tbl[10] = '{K_JRDN, 8'h00, 32'h0,        4'h0, 1'b0, 32'h11111111};
        tbl[11] = '{K_JRDA, 8'hFF, 32'h0,        4'h0, 1'b0, 32'h00000001};
        tbl[12] = '{K_CWR,  8'h20, 32'h12345678, 4'hF, 1'b0, 32'h0};
        tbl[13] = '{K_CRD,  8'h20, 32'h0,        4'h0, 1'b0, 32'h0};
        tbl[14] = '{K_CWR,  8'h20, 32'h12345678, 4'h3, 1'b1, 32'h0};
        tbl[15] = '{K_CRD,  8'h20, 32'h0,        4'h0, 1'b0, 32'h00005678};
        tbl[16] = '{K_CWR,  8'h20, 32'hAABBCCDD, 4'hC, 1'b1, 32'h0};
        tbl[17] = '{K_CRD,  8'h20, 32'h0,        4'h0, 1'b0, 32'hAABB5678};
        tbl[18] = '{K_CRD,  8'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        tbl[19] = '{K_JRDA, 8'h20, 32'h0,        4'h0, 1'b0, 32'hAABB5678};
        for (int i = 0; i < 20; i++) begin
            do_op(tbl[i].k, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].dbg, got, exp);
            if (tbl[i].k == K_JRDA || tbl[i].k == K_JRDN || tbl[i].k == K_CRD)
                chk($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        do_op(K_SETA, 8'h10, 32'h0, 4'h0, 1'b0, got, exp);
        cpu_address = 8'h10;
        cpu_read = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        w = 0;
        #1;
        while (cpu_waitrequest && w < 20) begin
            step;
            take_no_action_ocimem_a = 1'b0;
            w++;
            #1;
        end
        take_no_action_ocimem_a = 1'b0;
        step;
        cpu_read = 1'b0;
        chk("arb_waits", 32'(w), 32'd4);
        chk("arb_readdata", cpu_readdata, 32'hDEADBEEF);
        chk("arb_mondreg", MonDReg, 32'hDEADBEEF);
        m_a = 8'h11;

        do_op(K_SETA, 8'h40, 32'h0, 4'h0, 1'b0, got, exp);
        strobe(1'b0, 1'b0, 1'b1, jb(32'hC0FFEE01));
        strobe(1'b0, 1'b0, 1'b1, jb(32'hBAD0BAD0));
        chk("ovr_error_set", 32'(monitor_error), 32'd1);
        settle(w);
        m_mem[8'h40] = 32'hC0FFEE01;
        do_op(K_JRDA, 8'h41, 32'h0, 4'h0, 1'b0, got, exp);
        chk("ovr_dropped", got, 32'h0);
        do_op(K_JRDA, 8'h40, 32'h0, 4'h0, 1'b0, got, exp);
        chk("ovr_first_kept", got, 32'hC0FFEE01);
        chk("ovr_error_sticky", 32'(monitor_error), 32'd1);
        strobe(1'b1, 1'b0, 1'b0, ja(8'h50, 1'b0, 1'b1));
        chk("ovr_error_clr", 32'(monitor_error), 32'd0);
        do_op(K_SETA, 8'h60, 32'h0, 4'h0, 1'b0, got, exp);
        strobe(1'b0, 1'b0, 1'b1, jb(32'h600D0060));
        strobe(1'b1, 1'b0, 1'b0, ja(8'h70, 1'b0, 1'b0));
        chk("addr_only_no_error", 32'(monitor_error), 32'd0);
        settle(w);
        m_mem[8'h60] = 32'h600D0060;
        do_op(K_JRDA, 8'h60, 32'h0, 4'h0, 1'b0, got, exp);
        chk("addr_only_write", got, 32'h600D0060);

        do_op(K_SETA, 8'h80, 32'h0, 4'h0, 1'b0, got, exp);
        strobe(1'b0, 1'b0, 1'b1, jb(32'h80808080));
        strobe(1'b0, 1'b0, 1'b1, jb(32'h0BADBAD0));
        settle(w);
        m_mem[8'h80] = 32'h80808080;
        do_op(K_CRD, 8'h10, 32'h0, 4'h0, 1'b0, got, exp);
        strobe(1'b1, 1'b0, 1'b0, ja(8'h10, 1'b1, 1'b0));
        step;
        chk("pre_rst_ready", 32'(monitor_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(monitor_ready), 32'd1);
        chk("mid_rst_error", 32'(monitor_error), 32'd0);
        chk("mid_rst_mondreg", MonDReg, 32'h0);
        chk("mid_rst_readdata", cpu_readdata, 32'h0);
        chk("mid_rst_waitreq", 32'(cpu_waitrequest), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step;
        chk("post_rst_ready", 32'(monitor_ready), 32'd1);
        m_a = 8'h00;
        do_op(K_JRDN, 8'h00, 32'h0, 4'h0, 1'b0, got, exp);
        chk("post_rst_addr0", got, 32'hA5A5A5A5);

        for (int i = 0; i < 200; i++) begin
            int k;
            logic [7:0] a;
            k = $urandom_range(0, 5);
            a = 8'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 8'hF0 : 8'h00);
            do_op(k, a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), got, exp);
            if (k == K_JRDA || k == K_JRDN || k == K_CRD)
                chk($sformatf("rnd%0d_k%0d", i, k), got, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
